// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to an LFSR-style recurrence, then
// flags and counts bit errors against a free-running reference, dropping lock on bursts.
module prbs_checker #(
  parameter int               ORDER       = 3,
  parameter logic [ORDER-1:0] TAPS        = 3'b101,
  parameter int               LOCK_CNT    = 8,
  parameter int               WINDOW      = 64,
  parameter int               UNLOCK_ERRS = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             rx_bit_i,
  input  logic             rx_valid_i,
  input  logic             clear_cnt_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int FW = $clog2(ORDER + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e           state_q;
  logic [ORDER-1:0] hist_q;
  logic [FW-1:0]    fill_q;
  logic [MW-1:0]    match_q;
  logic [BW-1:0]    win_bits_q;
  logic [EW-1:0]    win_errs_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             lock_lost_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic          pred;
  logic          err;
  logic [MW-1:0] match_d;
  logic [BW-1:0] win_bits_d;
  logic [EW-1:0] win_errs_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    pred       = ^(hist_q & TAPS);
    err        = rx_bit_i ^ pred;
    match_d    = match_q + 1'b1;
    win_bits_d = win_bits_q + 1'b1;
    win_errs_d = win_errs_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      if (clear_cnt_i) err_cnt_q <= '0;
      if (rx_valid_i) begin
        if (state_q == SEARCH) begin
          hist_q <= {hist_q[ORDER-2:0], rx_bit_i};
          // A zero history predicts zero, so it must never count toward lock.
          if (fill_q != FW'(ORDER)) begin
            fill_q <= fill_q + 1'b1;
          end else if (hist_q != '0 && !err) begin
            if (match_d == MW'(LOCK_CNT)) begin
              state_q    <= LOCKED;
              locked_q   <= 1'b1;
              match_q    <= '0;
              win_bits_q <= '0;
              win_errs_q <= '0;
            end else begin
              match_q <= match_d;
            end
          end else begin
            match_q <= '0;
          end
        end else begin
          // Free-running reference: a single corrupted bit cannot disturb the history.
          hist_q <= {hist_q[ORDER-2:0], pred};
          if (err) begin
            err_pulse_q <= 1'b1;
            if (!clear_cnt_i) err_cnt_q <= sat_inc(err_cnt_q);
          end
          if (err && win_errs_d == EW'(UNLOCK_ERRS)) begin
            state_q     <= SEARCH;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b1;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
          end else if (win_bits_d == BW'(WINDOW)) begin
            win_bits_q <= '0;
            win_errs_q <= '0;
          end else begin
            win_bits_q <= win_bits_d;
            if (err) win_errs_q <= win_errs_d;
          end
        end
      end
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign lock_lost_o = lock_lost_q;
  assign err_count_o = err_cnt_q;

endmodule
